// File: rtl/difftest_step_batcher.sv
// Step batcher: folds per-cycle commit step counts from several difftest sources into
// fewer, larger nstep requests, then drains and freezes once the host reports a result.
module difftest_step_batcher #(
  parameter int unsigned STEP_WIDTH   = 8,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned ACC_WIDTH    = 16,
  parameter int unsigned BATCH_THRESH = 64,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC*STEP_WIDTH-1:0] src_step,
  output logic                          src_stall,
  input  logic [7:0]                    simv_result,
  output logic                          nstep_valid,
  output logic [ACC_WIDTH-1:0]          nstep_count,
  input  logic                          nstep_ready,
  output logic                          halted,
  output logic                          drop_err,
  output logic [63:0]                   total_steps
);

  localparam int unsigned TmrW = $clog2(TIMEOUT) + 1;
  localparam int unsigned MaxSum = NUM_SRC * ((2 ** STEP_WIDTH) - 1);
  // Above this level one more worst-case input cycle could wrap the accumulator.
  localparam logic [ACC_WIDTH-1:0] StallLimit = {ACC_WIDTH{1'b1}} - ACC_WIDTH'(MaxSum);
  localparam logic [ACC_WIDTH-1:0] Thresh = ACC_WIDTH'(BATCH_THRESH);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StAccum, StIssue, StDrain, StHalted} state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [TmrW-1:0]      tmr_q;
  logic                 valid_q;
  logic [ACC_WIDTH-1:0] count_q;
  logic                 drop_q;
  logic [63:0]          total_q;
  logic                 res_q;   // host result seen; drain once any open request completes

  logic [ACC_WIDTH-1:0] raw_sum;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] nxt;
  logic                 any_nz;
  logic                 drain_req;
  logic                 hs;

  // Sum the source slices; stalled cycles contribute nothing.
  always_comb begin
    raw_sum = '0;
    any_nz  = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      raw_sum = raw_sum + ACC_WIDTH'(src_step[i*STEP_WIDTH +: STEP_WIDTH]);
      any_nz  = any_nz | (|src_step[i*STEP_WIDTH +: STEP_WIDTH]);
    end
    sum       = src_stall ? '0 : raw_sum;
    nxt       = acc_q + sum;
    drain_req = res_q | (simv_result != 8'd0);
    hs        = valid_q & nstep_ready;
  end

  assign src_stall   = (state_q == StDrain) || (state_q == StHalted) || res_q ||
                       (acc_q > StallLimit);
  assign nstep_valid = valid_q;
  assign nstep_count = count_q;
  assign halted      = (state_q == StHalted);
  assign drop_err    = drop_q;
  assign total_steps = total_q;

  // Batching FSM with registered request outputs and synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      tmr_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      drop_q  <= 1'b0;
      total_q <= '0;
      res_q   <= 1'b0;
    end else begin
      res_q <= drain_req;
      if (src_stall && any_nz) drop_q <= 1'b1;
      if (hs) total_q <= total_q + 64'(count_q);

      case (state_q)
        StIdle: begin
          // Threshold wins over a simultaneous host result; drain follows the handshake.
          if (sum >= Thresh) begin
            valid_q <= 1'b1;
            count_q <= sum;
            acc_q   <= '0;
            state_q <= StIssue;
          end else if (drain_req) begin
            if (nxt != '0) begin
              valid_q <= 1'b1;
              count_q <= nxt;
              acc_q   <= '0;
              state_q <= StDrain;
            end else begin
              state_q <= StHalted;
            end
          end else if (sum != '0) begin
            acc_q   <= sum;
            tmr_q   <= '0;
            state_q <= StAccum;
          end
        end

        StAccum: begin
          if (nxt >= Thresh || tmr_q == TmrLast) begin
            valid_q <= 1'b1;
            count_q <= nxt;
            acc_q   <= '0;
            state_q <= StIssue;
          end else if (drain_req) begin
            valid_q <= 1'b1;
            count_q <= nxt;
            acc_q   <= '0;
            state_q <= StDrain;
          end else begin
            acc_q <= nxt;
            tmr_q <= tmr_q + TmrW'(1);
          end
        end

        StIssue: begin
          if (hs) begin
            valid_q <= 1'b0;
            acc_q   <= nxt;
            if (drain_req) begin
              // Residual goes out as a separate final request from DRAIN.
              state_q <= (nxt != '0) ? StDrain : StHalted;
            end else if (nxt != '0) begin
              tmr_q   <= '0;
              state_q <= StAccum;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            acc_q <= nxt;
          end
        end

        StDrain: begin
          if (valid_q) begin
            if (hs) begin
              valid_q <= 1'b0;
              state_q <= StHalted;
            end
          end else if (acc_q != '0) begin
            valid_q <= 1'b1;
            count_q <= acc_q;
            acc_q   <= '0;
          end else begin
            state_q <= StHalted;
          end
        end

        StHalted: begin
          valid_q <= 1'b0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher: threshold, timeout, back-pressure, overflow
// stall, drain/halt, drop error and reset during a pending request.
module tb_difftest_step_batcher;

  logic        clock;
  logic        reset;
  logic [15:0] src_step;
  logic        src_stall;
  logic [7:0]  simv_result;
  logic        nstep_valid;
  logic [15:0] nstep_count;
  logic        nstep_ready;
  logic        halted;
  logic        drop_err;
  logic [63:0] total_steps;

  int checks = 0;
  int fails  = 0;

  difftest_step_batcher #(
    .STEP_WIDTH  (8),
    .NUM_SRC     (2),
    .ACC_WIDTH   (16),
    .BATCH_THRESH(64),
    .TIMEOUT     (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .src_step   (src_step),
    .src_stall  (src_stall),
    .simv_result(simv_result),
    .nstep_valid(nstep_valid),
    .nstep_count(nstep_count),
    .nstep_ready(nstep_ready),
    .halted     (halted),
    .drop_err   (drop_err),
    .total_steps(total_steps)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input logic [7:0] a, input logic [7:0] b);
    src_step = {b, a};
  endtask

  task automatic test_reset();
    reset = 1'b0; set_src(0, 0); simv_result = 8'd0; nstep_ready = 1'b1;
    tick(); tick();
    if (nstep_valid !== 1'b0) begin $display("FAIL rst_valid: got %0b want 0", nstep_valid); fails++; end checks++;
    if (nstep_count !== 16'd0) begin $display("FAIL rst_count: got %0d want 0", nstep_count); fails++; end checks++;
    if (src_stall !== 1'b0) begin $display("FAIL rst_stall: got %0b want 0", src_stall); fails++; end checks++;
    if (halted !== 1'b0) begin $display("FAIL rst_halted: got %0b want 0", halted); fails++; end checks++;
    if (drop_err !== 1'b0) begin $display("FAIL rst_drop: got %0b want 0", drop_err); fails++; end checks++;
    if (total_steps !== 64'd0) begin $display("FAIL rst_total: got %0d want 0", total_steps); fails++; end checks++;
    reset = 1'b1;
  endtask

  task automatic test_threshold();
    nstep_ready = 1'b1;
    set_src(16, 16); tick();
    if (nstep_valid !== 1'b0) begin $display("FAIL thr_early: got %0b want 0", nstep_valid); fails++; end checks++;
    set_src(16, 16); tick();
    if (nstep_valid !== 1'b1 || nstep_count !== 16'd64) begin
      $display("FAIL thr_issue: got v=%0b c=%0d want v=1 c=64", nstep_valid, nstep_count); fails++;
    end checks++;
    set_src(0, 0); tick();
    if (nstep_valid !== 1'b0 || total_steps !== 64'd64) begin
      $display("FAIL thr_accept: got v=%0b tot=%0d want v=0 tot=64", nstep_valid, total_steps); fails++;
    end checks++;
  endtask

  task automatic test_timeout();
    set_src(1, 0); tick();
    set_src(0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        if (nstep_valid !== 1'b0) begin $display("FAIL tmo_early%0d: got 1 want 0", k); fails++; end checks++;
      end else begin
        if (nstep_valid !== 1'b1 || nstep_count !== 16'd1) begin
          $display("FAIL tmo_issue: got v=%0b c=%0d want v=1 c=1", nstep_valid, nstep_count); fails++;
        end checks++;
      end
    end
    tick();
    if (total_steps !== 64'd65) begin $display("FAIL tmo_total: got %0d want 65", total_steps); fails++; end checks++;
  endtask

  task automatic test_backpressure();
    nstep_ready = 1'b0;
    set_src(32, 32); tick();
    if (nstep_valid !== 1'b1 || nstep_count !== 16'd64) begin
      $display("FAIL bp_issue: got v=%0b c=%0d want v=1 c=64", nstep_valid, nstep_count); fails++;
    end checks++;
    set_src(5, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (nstep_valid !== 1'b1 || nstep_count !== 16'd64) begin
        $display("FAIL bp_hold%0d: got v=%0b c=%0d want v=1 c=64", k, nstep_valid, nstep_count); fails++;
      end checks++;
    end
    set_src(0, 0); nstep_ready = 1'b1; tick();
    if (nstep_valid !== 1'b0 || total_steps !== 64'd129) begin
      $display("FAIL bp_accept: got v=%0b tot=%0d want v=0 tot=129", nstep_valid, total_steps); fails++;
    end checks++;
    // Residual 50 sits in ACCUM with a fresh timer, so it times out 8 cycles later.
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7 && nstep_valid !== 1'b0) begin $display("FAIL bp_tmr: got 1 want 0"); fails++; end
      if (k == 7) checks++;
    end
    if (nstep_valid !== 1'b1 || nstep_count !== 16'd50) begin
      $display("FAIL bp_resid: got v=%0b c=%0d want v=1 c=50", nstep_valid, nstep_count); fails++;
    end checks++;
    tick();
    if (total_steps !== 64'd179) begin $display("FAIL bp_total: got %0d want 179", total_steps); fails++; end checks++;
  endtask

  task automatic test_overflow_stall();
    int n = 0;
    nstep_ready = 1'b0;
    set_src(255, 255); tick();
    if (nstep_valid !== 1'b1 || nstep_count !== 16'd510 || src_stall !== 1'b0) begin
      $display("FAIL ovf_issue: got v=%0b c=%0d s=%0b want v=1 c=510 s=0", nstep_valid, nstep_count,
               src_stall); fails++;
    end checks++;
    for (int k = 0; k < 200; k++) begin
      tick(); n++;
      if (src_stall) break;
    end
    set_src(0, 0);
    if (n !== 128 || src_stall !== 1'b1) begin
      $display("FAIL ovf_stall_at: got n=%0d s=%0b want n=128 s=1", n, src_stall); fails++;
    end checks++;
    nstep_ready = 1'b1; tick();
    if (nstep_valid !== 1'b0 || src_stall !== 1'b1 || total_steps !== 64'd689) begin
      $display("FAIL ovf_accept: got v=%0b s=%0b tot=%0d want v=0 s=1 tot=689", nstep_valid, src_stall,
               total_steps); fails++;
    end checks++;
    tick();
    if (nstep_valid !== 1'b1 || nstep_count !== 16'd65280 || src_stall !== 1'b0) begin
      $display("FAIL ovf_big: got v=%0b c=%0d s=%0b want v=1 c=65280 s=0", nstep_valid, nstep_count,
               src_stall); fails++;
    end checks++;
    tick();
    if (total_steps !== 64'd65969 || drop_err !== 1'b0) begin
      $display("FAIL ovf_total: got tot=%0d d=%0b want tot=65969 d=0", total_steps, drop_err); fails++;
    end checks++;
  endtask

  task automatic test_drain();
    nstep_ready = 1'b1;
    set_src(30, 0); tick();
    if (nstep_valid !== 1'b0) begin $display("FAIL drn_accum: got 1 want 0"); fails++; end checks++;
    set_src(0, 0); simv_result = 8'd3; tick();
    if (src_stall !== 1'b1 || nstep_valid !== 1'b1 || nstep_count !== 16'd30 || halted !== 1'b0) begin
      $display("FAIL drn_final: got s=%0b v=%0b c=%0d h=%0b want s=1 v=1 c=30 h=0", src_stall,
               nstep_valid, nstep_count, halted); fails++;
    end checks++;
    simv_result = 8'd0; tick();
    if (halted !== 1'b1 || nstep_valid !== 1'b0 || total_steps !== 64'd65999) begin
      $display("FAIL drn_halt: got h=%0b v=%0b tot=%0d want h=1 v=0 tot=65999", halted, nstep_valid,
               total_steps); fails++;
    end checks++;
  endtask

  task automatic test_drop();
    set_src(7, 9); tick();
    if (drop_err !== 1'b1 || total_steps !== 64'd65999 || nstep_valid !== 1'b0) begin
      $display("FAIL drop_set: got d=%0b tot=%0d v=%0b want d=1 tot=65999 v=0", drop_err, total_steps,
               nstep_valid); fails++;
    end checks++;
    set_src(0, 0); tick(); tick();
    if (drop_err !== 1'b1 || halted !== 1'b1 || src_stall !== 1'b1) begin
      $display("FAIL drop_sticky: got d=%0b h=%0b s=%0b want 1 1 1", drop_err, halted, src_stall); fails++;
    end checks++;
  endtask

  task automatic test_reset_mid_issue();
    reset = 1'b0; tick(); reset = 1'b1;
    nstep_ready = 1'b0;
    set_src(40, 40); tick();
    if (nstep_valid !== 1'b1 || nstep_count !== 16'd80) begin
      $display("FAIL rmi_issue: got v=%0b c=%0d want v=1 c=80", nstep_valid, nstep_count); fails++;
    end checks++;
    set_src(0, 0); reset = 1'b0; tick();
    if (nstep_valid !== 1'b0 || nstep_count !== 16'd0 || src_stall !== 1'b0 || halted !== 1'b0 ||
        drop_err !== 1'b0 || total_steps !== 64'd0) begin
      $display("FAIL rmi_clear: got v=%0b c=%0d s=%0b h=%0b d=%0b tot=%0d want all 0", nstep_valid,
               nstep_count, src_stall, halted, drop_err, total_steps); fails++;
    end checks++;
    reset = 1'b1; nstep_ready = 1'b1; tick();
    if (nstep_valid !== 1'b0 || total_steps !== 64'd0) begin
      $display("FAIL rmi_abandon: got v=%0b tot=%0d want v=0 tot=0", nstep_valid, total_steps); fails++;
    end checks++;
  endtask

  task automatic test_drain_from_issue();
    nstep_ready = 1'b0;
    set_src(32, 32); tick();
    set_src(6, 0); simv_result = 8'd2; tick();
    if (src_stall !== 1'b1 || nstep_valid !== 1'b1 || nstep_count !== 16'd64) begin
      $display("FAIL dfi_hold: got s=%0b v=%0b c=%0d want s=1 v=1 c=64", src_stall, nstep_valid,
               nstep_count); fails++;
    end checks++;
    set_src(0, 0); simv_result = 8'd0; nstep_ready = 1'b1; tick();
    if (nstep_valid !== 1'b0 || halted !== 1'b0 || total_steps !== 64'd64) begin
      $display("FAIL dfi_accept: got v=%0b h=%0b tot=%0d want v=0 h=0 tot=64", nstep_valid, halted,
               total_steps); fails++;
    end checks++;
    tick();
    if (nstep_valid !== 1'b1 || nstep_count !== 16'd6) begin
      $display("FAIL dfi_final: got v=%0b c=%0d want v=1 c=6", nstep_valid, nstep_count); fails++;
    end checks++;
    tick();
    if (halted !== 1'b1 || nstep_valid !== 1'b0 || total_steps !== 64'd70) begin
      $display("FAIL dfi_halt: got h=%0b v=%0b tot=%0d want h=1 v=0 tot=70", halted, nstep_valid,
               total_steps); fails++;
    end checks++;
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_timeout();
    test_backpressure();
    test_overflow_stall();
    test_drain();
    test_drop();
    test_reset_mid_issue();
    test_drain_from_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
